// File: rtl/conv_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : conv_addr_gen
// Description : 3x3 "valid" convolution window address generator. Emits the
//               nine input-pixel addresses per output pixel, one per handshake.
//               Build option CONV_STRIDE2_EN steps the output grid by 2.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_addr_gen #(
    parameter int ADDR_W = 12,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [3:0]        tap,
    output logic              last_tap,
    output logic              last_pixel,
    output logic              busy,
    output logic              done
);

`ifdef CONV_STRIDE2_EN
    localparam int C_STEP = 2;
`else
    localparam int C_STEP = 1;
`endif

    localparam int C_DIM_MAX = (IMG_W > IMG_H) ? IMG_W : IMG_H;
    localparam int C_CW      = $clog2(C_DIM_MAX) + 1;

    // Final output row/column on the stride grid
    localparam logic [C_CW-1:0] C_R_LAST = C_CW'(((IMG_H - 3) / C_STEP) * C_STEP);
    localparam logic [C_CW-1:0] C_C_LAST = C_CW'(((IMG_W - 3) / C_STEP) * C_STEP);
    localparam logic [C_CW-1:0] C_STEP_V = C_CW'(C_STEP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] w_base_nxt;
    logic [C_CW-1:0]   r_row;
    logic [C_CW-1:0]   r_col;
    logic [C_CW-1:0]   w_row_nxt;
    logic [C_CW-1:0]   w_col_nxt;
    logic [1:0]        r_kr;
    logic [1:0]        r_kc;
    logic [1:0]        w_kr_nxt;
    logic [1:0]        w_kc_nxt;

    logic [ADDR_W-1:0] r_addr_out;
    logic              r_valid;
    logic [3:0]        r_tap;
    logic              r_last_tap;
    logic              r_last_pixel;
    logic              r_busy;
    logic              r_done;

    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_valid_nxt;
    logic [3:0]        w_tap_nxt;
    logic              w_last_tap_nxt;
    logic              w_last_pixel_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;

    logic              w_fire;
    logic              w_load;
    logic [C_CW-1:0]   w_row_sum;
    logic [C_CW-1:0]   w_col_sum;
    logic [ADDR_W-1:0] w_offset;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_base_nxt       = r_base;
        w_row_nxt        = r_row;
        w_col_nxt        = r_col;
        w_kr_nxt         = r_kr;
        w_kc_nxt         = r_kc;
        w_valid_nxt      = r_valid;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_addr_nxt       = r_addr_out;
        w_tap_nxt        = r_tap;
        w_last_tap_nxt   = r_last_tap;
        w_last_pixel_nxt = r_last_pixel;
        w_load           = 1'b0;
        w_fire           = r_valid && addr_ready;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_base_nxt  = base_addr;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                    w_kr_nxt    = 2'd0;
                    w_kc_nxt    = 2'd0;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_load      = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_fire) begin
                    if (r_last_tap && r_last_pixel) begin
                        w_state_nxt = ST_DONE;
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        // Odometer: kc fastest, then kr, then c, then r
                        w_load = 1'b1;
                        if (r_kc != 2'd2) begin
                            w_kc_nxt = r_kc + 2'd1;
                        end else begin
                            w_kc_nxt = 2'd0;
                            if (r_kr != 2'd2) begin
                                w_kr_nxt = r_kr + 2'd1;
                            end else begin
                                w_kr_nxt = 2'd0;
                                if (r_col != C_C_LAST) begin
                                    w_col_nxt = r_col + C_STEP_V;
                                end else begin
                                    w_col_nxt = '0;
                                    w_row_nxt = r_row + C_STEP_V;
                                end
                            end
                        end
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Address of the upcoming window element; wraps modulo 2^ADDR_W
        w_row_sum = w_row_nxt + C_CW'(w_kr_nxt);
        w_col_sum = w_col_nxt + C_CW'(w_kc_nxt);
        w_offset  = ADDR_W'(32'(w_row_sum) * 32'(IMG_W) + 32'(w_col_sum));

        if (w_load) begin
            w_addr_nxt       = w_base_nxt + w_offset;
            w_tap_nxt        = {2'b00, w_kr_nxt} * 4'd3 + {2'b00, w_kc_nxt};
            w_last_tap_nxt   = (w_kr_nxt == 2'd2) && (w_kc_nxt == 2'd2);
            w_last_pixel_nxt = (w_row_nxt == C_R_LAST) && (w_col_nxt == C_C_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base       <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_kr         <= 2'd0;
            r_kc         <= 2'd0;
            r_addr_out   <= '0;
            r_valid      <= 1'b0;
            r_tap        <= 4'd0;
            r_last_tap   <= 1'b0;
            r_last_pixel <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_base       <= w_base_nxt;
            r_row        <= w_row_nxt;
            r_col        <= w_col_nxt;
            r_kr         <= w_kr_nxt;
            r_kc         <= w_kc_nxt;
            r_addr_out   <= w_addr_nxt;
            r_valid      <= w_valid_nxt;
            r_tap        <= w_tap_nxt;
            r_last_tap   <= w_last_tap_nxt;
            r_last_pixel <= w_last_pixel_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign addr_out   = r_addr_out;
    assign addr_valid = r_valid;
    assign tap        = r_tap;
    assign last_tap   = r_last_tap;
    assign last_pixel = r_last_pixel;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire
